// File: rtl/alu_decode_stage_if.sv
// Handshake bundle between fetch/regfile read, the ALU decode stage and execute.
// Carries instruction input, regfile addresses/data, decoded ALU bundle and stats.
interface alu_decode_stage_if #(
    parameter int STAT_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       inst;
    logic [4:0]        rs_addr;
    logic [4:0]        rt_addr;
    logic [31:0]       rs_data;
    logic [31:0]       rt_data;
    logic              out_valid;
    logic              out_ready;
    logic [11:0]       alu_control;
    logic [31:0]       alu_src1;
    logic [31:0]       alu_src2;
    logic [4:0]        dest;
    logic              illegal;
    logic [STAT_W-1:0] stat_decoded;
    logic [STAT_W-1:0] stat_illegal;

    modport slave (
        input  in_valid, inst, rs_data, rt_data, out_ready,
        output in_ready, rs_addr, rt_addr, out_valid,
        output alu_control, alu_src1, alu_src2, dest, illegal,
        output stat_decoded, stat_illegal
    );

    modport master (
        output in_valid, inst, rs_data, rt_data, out_ready,
        input  in_ready, rs_addr, rt_addr, out_valid,
        input  alu_control, alu_src1, alu_src2, dest, illegal,
        input  stat_decoded, stat_illegal
    );
endinterface

// File: rtl/alu_decode_stage.sv
// MIPS decode stage feeding a 12-op one-hot ALU through one registered slot.
// Define ALU_DEC_STAT_EN to build the saturating decoded/illegal counters.
module alu_decode_stage #(
    parameter int STAT_W = 16
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            flush,
    alu_decode_stage_if.slave bus
);
    localparam logic [11:0] C_ADD  = 12'h800;
    localparam logic [11:0] C_SUB  = 12'h400;
    localparam logic [11:0] C_SLT  = 12'h200;
    localparam logic [11:0] C_SLTU = 12'h100;
    localparam logic [11:0] C_AND  = 12'h080;
    localparam logic [11:0] C_NOR  = 12'h040;
    localparam logic [11:0] C_OR   = 12'h020;
    localparam logic [11:0] C_XOR  = 12'h010;
    localparam logic [11:0] C_SLL  = 12'h008;
    localparam logic [11:0] C_SRL  = 12'h004;
    localparam logic [11:0] C_SRA  = 12'h002;
    localparam logic [11:0] C_LUI  = 12'h001;

    logic [5:0]  op;
    logic [5:0]  funct;
    logic [31:0] shamt;
    logic [31:0] sext;
    logic [31:0] zext;

    logic [11:0] d_ctrl;
    logic [31:0] d_src1;
    logic [31:0] d_src2;
    logic [4:0]  d_dest;
    logic        d_ill;

    logic        valid_q;
    logic [11:0] ctrl_q;
    logic [31:0] src1_q;
    logic [31:0] src2_q;
    logic [4:0]  dest_q;
    logic        ill_q;
    logic        accept;

    assign op    = bus.inst[31:26];
    assign funct = bus.inst[5:0];
    assign shamt = {27'b0, bus.inst[10:6]};
    assign sext  = {{16{bus.inst[15]}}, bus.inst[15:0]};
    assign zext  = {16'b0, bus.inst[15:0]};

    assign bus.rs_addr  = bus.inst[25:21];
    assign bus.rt_addr  = bus.inst[20:16];
    assign bus.in_ready = ~valid_q | bus.out_ready;
    assign accept       = bus.in_valid & bus.in_ready & ~flush;

    always_comb begin
        d_ctrl = '0;
        d_src1 = '0;
        d_src2 = '0;
        d_dest = '0;
        d_ill  = 1'b0;
        unique case (op)
            6'h00: begin
                d_src1 = bus.rs_data;
                d_src2 = bus.rt_data;
                d_dest = bus.inst[15:11];
                unique case (funct)
                    6'h20, 6'h21: d_ctrl = C_ADD;
                    6'h22, 6'h23: d_ctrl = C_SUB;
                    6'h2A:        d_ctrl = C_SLT;
                    6'h2B:        d_ctrl = C_SLTU;
                    6'h24:        d_ctrl = C_AND;
                    6'h25:        d_ctrl = C_OR;
                    6'h26:        d_ctrl = C_XOR;
                    6'h27:        d_ctrl = C_NOR;
                    6'h00: begin d_ctrl = C_SLL; d_src1 = shamt; end
                    6'h02: begin d_ctrl = C_SRL; d_src1 = shamt; end
                    6'h03: begin d_ctrl = C_SRA; d_src1 = shamt; end
                    6'h04:        d_ctrl = C_SLL;
                    6'h06:        d_ctrl = C_SRL;
                    6'h07:        d_ctrl = C_SRA;
                    default:      d_ill  = 1'b1;
                endcase
            end
            6'h08, 6'h09, 6'h0A, 6'h0B,
            6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
                d_src1 = bus.rs_data;
                d_src2 = zext;
                d_dest = bus.inst[20:16];
                unique case (op)
                    6'h08, 6'h09: begin d_ctrl = C_ADD;  d_src2 = sext; end
                    6'h0A:        begin d_ctrl = C_SLT;  d_src2 = sext; end
                    6'h0B:        begin d_ctrl = C_SLTU; d_src2 = sext; end
                    6'h0C:        d_ctrl = C_AND;
                    6'h0D:        d_ctrl = C_OR;
                    6'h0E:        d_ctrl = C_XOR;
                    default: begin d_ctrl = C_LUI; d_src1 = '0; end
                endcase
            end
            default: d_ill = 1'b1;
        endcase
        // Unsupported encodings present an all-zero bundle downstream
        if (d_ill) begin
            d_ctrl = '0;
            d_src1 = '0;
            d_src2 = '0;
            d_dest = '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            src1_q  <= '0;
            src2_q  <= '0;
            dest_q  <= '0;
            ill_q   <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q <= 1'b1;
            ctrl_q  <= d_ctrl;
            src1_q  <= d_src1;
            src2_q  <= d_src2;
            dest_q  <= d_dest;
            ill_q   <= d_ill;
        end else if (valid_q && bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.out_valid   = valid_q;
    assign bus.alu_control = ctrl_q;
    assign bus.alu_src1    = src1_q;
    assign bus.alu_src2    = src2_q;
    assign bus.dest        = dest_q;
    assign bus.illegal     = ill_q;

`ifdef ALU_DEC_STAT_EN
    logic [STAT_W-1:0] n_dec;
    logic [STAT_W-1:0] n_ill;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            n_dec <= '0;
            n_ill <= '0;
        end else if (accept) begin
            if (n_dec != '1) n_dec <= n_dec + 1'b1;
            if (d_ill && n_ill != '1) n_ill <= n_ill + 1'b1;
        end
    end

    assign bus.stat_decoded = n_dec;
    assign bus.stat_illegal = n_ill;
`else
    assign bus.stat_decoded = {STAT_W{1'b0}};
    assign bus.stat_illegal = {STAT_W{1'b0}};
`endif
endmodule

// File: doc/alu_decode_stage.md
Name: alu_decode_stage

Overview:
- Decode stage that produces the operand/control bundle consumed by the 12-op ALU: 12-bit one-hot alu_control, alu_src1, alu_src2.
- Accepts one MIPS instruction per handshake plus its register-file read data, decodes it and holds the result in a single registered output slot.
- Sits between fetch/regfile read and the execute stage; valid/ready on both sides; flush support.

Parameters:
- STAT_W, 16, width of the optional saturating statistics counters.

Ports:
- clk  in  1  clock, all state on rising edge
- resetn  in  1  asynchronous active-low reset
- flush  in  1  discard slot contents and any capture this cycle
- in_valid  in  1  instruction offered
- in_ready  out  1  stage can accept (combinational)
- inst  in  32  instruction word
- rs_addr  out  5  inst[25:21], combinational, to regfile read port 1
- rt_addr  out  5  inst[20:16], combinational, to regfile read port 2
- rs_data  in  32  regfile data for rs_addr, same cycle
- rt_data  in  32  regfile data for rt_addr, same cycle
- out_valid  out  1  slot holds a decoded op
- out_ready  in  1  execute stage accepts
- alu_control  out  12  one-hot; bit11 add, 10 sub, 9 slt, 8 sltu, 7 and, 6 nor, 5 or, 4 xor, 3 sll, 2 srl, 1 sra, 0 lui
- alu_src1  out  32  ALU operand 1
- alu_src2  out  32  ALU operand 2
- dest  out  5  writeback register, 0 = no write
- illegal  out  1  decoded instruction not in supported subset
- stat_decoded  out  STAT_W  count of accepted instructions
- stat_illegal  out  STAT_W  count of accepted illegal instructions

Behaviour:
- Reset (resetn low, async): out_valid=0, alu_control=0, alu_src1=0, alu_src2=0, dest=0, illegal=0, stats=0.
- in_ready = ~out_valid | out_ready. Accept = in_valid & in_ready & ~flush.
- Accept: slot loads decoded bundle next edge, out_valid=1; latency 1 cycle, throughput 1/cycle when out_ready held high.
- out_valid & out_ready & ~accept: out_valid falls to 0; payload registers hold.
- out_valid & ~out_ready: all outputs stable until taken.
- flush: out_valid=0 next edge regardless of in_valid/out_ready; nothing captured; stats not incremented.
- R-type (op=0x00), src2=rt_data, dest=inst[15:11]:
  - ADD 0x20, ADDU 0x21 -> add; SUB 0x22, SUBU 0x23 -> sub.
  - SLT 0x2A -> slt; SLTU 0x2B -> sltu.
  - AND 0x24, OR 0x25, XOR 0x26, NOR 0x27 -> matching bit.
  - These use src1=rs_data.
  - SLL 0x00, SRL 0x02, SRA 0x03: src1={27'b0, inst[10:6]}.
  - SLLV 0x04, SRLV 0x06, SRAV 0x07: src1=rs_data.
- I-type, src1=rs_data, dest=inst[20:16]:
  - ADDI 0x08, ADDIU 0x09 -> add; SLTI 0x0A -> slt; SLTIU 0x0B -> sltu. src2 is sign-extended imm[15:0].
  - ANDI 0x0C, ORI 0x0D, XORI 0x0E: src2 is zero-extended imm.
  - LUI 0x0F -> lui, src2 zero-extended imm, src1=0.
- Any other op/funct: alu_control=0, src1=0, src2=0, dest=0, illegal=1.
- Exactly one alu_control bit is set for every legal op.
- inst=0 decodes as SLL with dest=0 (nop), illegal=0.

Optional Feature:
- ALU_DEC_STAT_EN defined: stat_decoded increments on every accept. stat_illegal increments on every accept of an illegal instruction. Both saturate at all-ones.
- Undefined: both stat ports tied to 0, no counter flops.

Test Plan:
- Reset mid-stream: with out_valid=1, drop resetn asynchronously -> out_valid=0, all outputs 0 immediately, stats 0.
- ADDI r2,r1,-1 (0x2022FFFF), rs_data=5, out_ready=1 -> next cycle alu_control=0x800, src1=5, src2=0xFFFFFFFF, dest=2, illegal=0.
- SRA r3,r4,7 (0x000419C3), rt_data=0x80000000 -> alu_control=0x002, src1=7, src2=0x80000000, dest=3. LUI r5,0x1234 (0x3C051234) -> alu_control=0x001, src2=0x00001234, dest=5.
- Backpressure: out_ready=0 for 3 cycles after SUB accepted -> in_ready=0, outputs stable. out_ready=1 -> next queued op loads the same edge, no bubble, no loss.
- Illegal opcode 0xFC000000 -> illegal=1, alu_control=0, dest=0. With ALU_DEC_STAT_EN: stat_illegal=1, stat_decoded=1.
- flush asserted together with in_valid=1 while out_valid=1 -> out_valid=0 next cycle, op not captured, stats unchanged.
